usb_bridge_arbiter: RTL and testbench

//  Shares the single FT parallel-port USB bridge between NUM_REQ requesters (e.g. command decoder, status poller, DMA).

---
 rtl/usb_bridge_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/usb_bridge_arbiter.sv | 128 ++++++++++++
 tb/tb_usb_bridge_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_bridge_pkg.sv
// usb_bridge_pkg
//   Shared types and constants for the USB bridge arbiter.
//   state_t            : arbiter FSM states
//   BRIDGE_NOMINAL_LAT : cycles from strobe rise until the bridge reports finished
//   BYTE_W             : bridge data width
//   idx_w()            : index width for an N-way selector (at least 1 bit)
package usb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_BUSY  = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int BRIDGE_NOMINAL_LAT = 4;
    localparam int BYTE_W             = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational NUM_REQ-way round-robin picker.
//   req        : pending request vector
//   ptr        : highest-priority index for this pick
//   gnt_onehot : one-hot winner (all zero when nothing pending)
//   gnt_idx    : binary winner index
//   any        : at least one request pending
module rr_arbiter
    import usb_bridge_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    // Walk the requesters starting at ptr, wrapping once; first set bit wins.
    always_comb begin
        int k;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        k          = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!any && req[k]) begin
                any           = 1'b1;
                gnt_idx       = IDX_W'(k);
                gnt_onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_bridge_arbiter.sv
// usb_bridge_arbiter
//   Shares one FT parallel-port USB bridge between NUM_REQ requesters.
//   Round-robin grant, one strobe per transaction, timeout on a hung bridge,
//   and a post-reset flush window that ignores stale br_finished pulses.
//   req/req_wr/req_wdata : requester side, req held until its done pulse
//   done/rdata/err       : completion pulse, read byte, timeout flag
//   busy                 : FSM not idle
//   br_*                 : bridge strobe/data interface
module usb_bridge_arbiter
    import usb_bridge_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int TIMEOUT      = 64,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [BYTE_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [BYTE_W-1:0]         rdata,
    output logic                      err,
    output logic                      busy,
    output logic                      br_write_sig,
    output logic                      br_read_sig,
    output logic [BYTE_W-1:0]         br_write_data,
    input  logic [BYTE_W-1:0]         br_read_data,
    input  logic                      br_finished
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam int DR_W  = $clog2(DRAIN_CYCLES + 1);

    state_t             state;
    logic [DR_W-1:0]    drain_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant_oh;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req        (req),
        .ptr        (rr_ptr),
        .gnt_onehot (pick_oh),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_FLUSH;
            drain_cnt     <= '0;
            to_cnt        <= '0;
            rr_ptr        <= '0;
            grant_oh      <= '0;
            done          <= '0;
            rdata         <= '0;
            err           <= 1'b0;
            busy          <= 1'b0;
            br_write_sig  <= 1'b0;
            br_read_sig   <= 1'b0;
            br_write_data <= '0;
        end else begin
            case (state)
                // The bridge itself is not reset and may still complete a
                // transfer started before reset; sit out that window.
                ST_FLUSH: begin
                    if (drain_cnt == DR_W'(DRAIN_CYCLES - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_oh      <= pick_oh;
                        br_write_data <= req_wdata[int'(pick_idx)*BYTE_W +: BYTE_W];
                        br_write_sig  <= req_wr[pick_idx];
                        br_read_sig   <= !req_wr[pick_idx];
                        to_cnt        <= '0;
                        err           <= 1'b0;
                        busy          <= 1'b1;
                        rr_ptr        <= (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
                        state         <= ST_BUSY;
                    end
                end
                // finished is tested first so it wins over a same-edge timeout.
                ST_BUSY: begin
                    if (br_finished) begin
                        br_write_sig <= 1'b0;
                        br_read_sig  <= 1'b0;
                        if (br_read_sig) rdata <= br_read_data;
                        err          <= 1'b0;
                        done         <= grant_oh;
                        state        <= ST_DONE;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        br_write_sig <= 1'b0;
                        br_read_sig  <= 1'b0;
                        rdata        <= '0;
                        err          <= 1'b1;
                        done         <= grant_oh;
                        state        <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= '0;
                    state <= ST_GAP;
                end
                // One strobe-free cycle lets the bridge return to idle.
                ST_GAP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_FLUSH;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_bridge_arbiter.sv
// tb_usb_bridge_arbiter
//   Directed + randomized bench: a behavioural bridge model answers strobes
//   after a fixed latency (or hangs), and a round-robin scoreboard predicts
//   the winner, data and status of every completion.
module tb_usb_bridge_arbiter;
    import usb_bridge_pkg::*;

    localparam int N       = 3;
    localparam int TO      = 64;
    localparam int DRAIN   = 4;
    localparam int LAT     = BRIDGE_NOMINAL_LAT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     req_wr = '0;
    logic [8*N-1:0]   req_wdata = '0;
    logic [N-1:0]     done;
    logic [7:0]       rdata;
    logic             err;
    logic             busy;
    logic             br_write_sig;
    logic             br_read_sig;
    logic [7:0]       br_write_data;
    logic [7:0]       br_read_data;
    logic             br_finished;

    usb_bridge_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .DRAIN_CYCLES(DRAIN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_wr        (req_wr),
        .req_wdata     (req_wdata),
        .done          (done),
        .rdata         (rdata),
        .err           (err),
        .busy          (busy),
        .br_write_sig  (br_write_sig),
        .br_read_sig   (br_read_sig),
        .br_write_data (br_write_data),
        .br_read_data  (br_read_data),
        .br_finished   (br_finished)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- bridge model ----------------
    logic       hang = 1'b0;
    logic       force_rd = 1'b0;
    logic [7:0] force_val = '0;
    logic       stray_fin = 1'b0;
    logic       fin_model = 1'b0;
    logic [7:0] rd_byte = '0;
    logic       seen_wr = 1'b0;
    logic [7:0] seen_wbyte = '0;
    int         hc = 0;
    int         last_len = 0;
    int         strobes_seen = 0;

    assign br_finished  = fin_model | stray_fin;
    assign br_read_data = rd_byte;

    always @(negedge clk) begin
        if (br_write_sig || br_read_sig) begin
            hc++;
            chk("one_strobe", 32'({br_write_sig, br_read_sig} != 2'b11), 32'd1);
            chk("busy_with_strobe", 32'(busy), 32'd1);
            if (hc == 1) begin
                seen_wr    = br_write_sig;
                seen_wbyte = br_write_data;
                rd_byte    = force_rd ? force_val : 8'($urandom);
                strobes_seen++;
            end else begin
                chk("wdata_stable", 32'(br_write_data), 32'(seen_wbyte));
                chk("kind_stable", 32'(br_write_sig), 32'(seen_wr));
            end
        end else begin
            if (hc != 0) last_len = hc;
            hc = 0;
        end
        fin_model = !hang && (hc == LAT);
    end

    // ---------------- scoreboard ----------------
    int         exp_ptr = 0;
    int         last_w = 0;
    logic [7:0] exp_rdata = '0;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic raise(input int i);
        req[i]             = 1'b1;
        req_wr[i]          = 1'($urandom);
        req_wdata[i*8 +: 8] = 8'($urandom);
    endtask

    // Predict the round-robin winner, wait for its done and check the result.
    // Returns one cycle after done, i.e. in the GAP cycle.
    task automatic run_one(input string tag, input bit exp_err);
        int w;
        int n;
        int seen0;
        w = -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (exp_ptr + i) % N;
            if (w < 0 && req[k]) w = k;
        end
        if (w < 0) w = 0;
        seen0 = strobes_seen;
        n = 0;
        while (done === '0 && n < 300) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'(1 << w));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_one_xfer"}, 32'(strobes_seen - seen0), 32'd1);
        chk({tag, "_kind"}, 32'(seen_wr), 32'(req_wr[w]));
        if (exp_err) begin
            exp_rdata = '0;
            chk({tag, "_len"}, 32'(last_len), 32'(TO));
        end else begin
            if (req_wr[w]) chk({tag, "_wbyte"}, 32'(seen_wbyte), 32'(req_wdata[w*8 +: 8]));
            else exp_rdata = rd_byte;
            chk({tag, "_len"}, 32'(last_len), 32'(LAT));
        end
        chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
        exp_ptr = (w + 1) % N;
        last_w  = w;
        step();
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        int fair_seq[4];
        int n;
        fair_seq = '{0, 1, 0, 1};

        // reset
        #2 rst_n = 1'b0;
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", 32'({br_write_sig, br_read_sig}), 32'd0);
        chk("rst_wdata", 32'(br_write_data), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        // stale finished during the flush window must do nothing
        step();
        stray_fin = 1'b1;
        step();
        stray_fin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flush_no_done", 32'(done), 32'd0);
        end

        // 1: write 0xA5 from requester 0
        req_wr[0] = 1'b1; req_wdata[7:0] = 8'hA5; req[0] = 1'b1;
        run_one("wr", 1'b0);
        chk("wr_byte_a5", 32'(seen_wbyte), 32'hA5);
        req[0] = 1'b0;

        // 2: read 0x3C into requester 1
        force_rd = 1'b1; force_val = 8'h3C;
        req_wr[1] = 1'b0; req[1] = 1'b1;
        run_one("rd", 1'b0);
        chk("rd_3c", 32'(rdata), 32'h3C);
        req[1] = 1'b0; force_rd = 1'b0;

        // 3: fairness with two requesters held
        req[0] = 1'b1; req[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_one("fair", 1'b0);
            chk("fair_order", 32'(last_w), 32'(fair_seq[i]));
            chk("gap_strobes", 32'({br_write_sig, br_read_sig}), 32'd0);
        end
        req = '0;

        // 4: hung bridge, then a normal read clears err
        hang = 1'b1;
        req_wr[0] = 1'b0; req[0] = 1'b1;
        run_one("timeout", 1'b1);
        req[0] = 1'b0; hang = 1'b0;
        req_wr[1] = 1'b0; req[1] = 1'b1;
        run_one("post_to", 1'b0);
        req[1] = 1'b0;

        // 5: reset two cycles into BUSY
        req_wr[2] = 1'b0; req[2] = 1'b1;
        n = 0;
        while (!(br_write_sig || br_read_sig) && n < 50) begin step(); n++; end
        chk("strobe_seen", 32'(br_write_sig | br_read_sig), 32'd1);
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'({br_write_sig, br_read_sig}), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rdata", 32'(rdata), 32'd0);
        exp_ptr = 0; exp_rdata = '0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < DRAIN; i++) begin
            step();
            stray_fin = (i == 1);
            chk("flush_no_strobe", 32'({br_write_sig, br_read_sig}), 32'd0);
            chk("flush_done", 32'(done), 32'd0);
        end
        stray_fin = 1'b0;
        run_one("after_rst", 1'b0);
        req[2] = 1'b0;

        // 6: finished outside BUSY (in GAP now, then in IDLE)
        stray_fin = 1'b1;
        step();
        stray_fin = 1'b0;
        chk("gap_fin_done", 32'(done), 32'd0);
        chk("gap_fin_busy", 32'(busy), 32'd0);
        step();
        stray_fin = 1'b1;
        step();
        stray_fin = 1'b0;
        step();
        chk("idle_fin_done", 32'(done), 32'd0);
        chk("idle_fin_busy", 32'(busy), 32'd0);
        chk("idle_fin_strobes", 32'({br_write_sig, br_read_sig}), 32'd0);

        // randomized traffic
        raise(0);
        for (int t = 0; t < 30; t++) begin
            run_one("rand", 1'b0);
            req[last_w] = 1'b0;
            for (int i = 0; i < N; i++)
                if (!req[i] && ($urandom % 3 == 0)) raise(i);
            if (req == '0) raise(int'($urandom % N));
        end
        req = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
